poly_mult_seq: RTL and testbench
================================

POLY_MULT_SEQ -- requirements
Module: poly_mult_seq

Interface
REQ-001 SHALL have parameter MAX_WEIGHT, default 75: largest accepted sparse weight.
REQ-002 SHALL have parameter LOG_MAX_WEIGHT, default 7: CLOG2(MAX_WEIGHT).
REQ-003 SHALL have parameter M, default 15: location word width.
REQ-004 SHALL have parameter ADDR_WIDTH, default 11: result address width.
REQ-005 SHALL have parameter MEM_WIDTH, default 32: result word width.
REQ-006 SHALL have parameter RESULT_WORDS, default 553: words read out per job (N_MEM/MEM_WIDTH).
REQ-007 SHALL have parameter TIMEOUT, default 2**20: maximum WAIT cycles.
REQ-008 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_weight  in  LOG_MAX_WEIGHT+1  location count for the job.
- loc_valid  in  1  location beat valid.
- loc_ready  out  1  high only in LOAD.
- loc_data  in  M  location value.
- loc_wr_en  out  1  position RAM write strobe.
- loc_wr_addr  out  LOG_MAX_WEIGHT  position RAM address.
- loc_wr_data  out  M  position RAM data.
- pm_start  out  1  one-cycle start to poly_mult.
- pm_weight  out  LOG_MAX_WEIGHT+1  latched job weight.
- pm_valid  in  1  poly_mult completion level.
- pm_rd_dout  out  1  result read enable.
- pm_addr_result  out  ADDR_WIDTH  result read address.
- pm_dout  in  MEM_WIDTH  result word, valid one cycle after address.
- res_valid  out  1  result stream valid.
- res_ready  in  1  result stream ready.
- res_data  out  MEM_WIDTH  result word.
- res_last  out  1  marks word RESULT_WORDS-1.
- busy  out  1  high whenever not IDLE.
- done  out  1  one-cycle pulse after last beat accepted.
- err  out  1  one-cycle pulse on reject or timeout.

Function
REQ-009 SHALL have states IDLE, LOAD, START, WAIT, RADDR, RDATA, OUT.
REQ-010 IDLE: handshake cmd_valid&cmd_ready with 1<=cmd_weight<=MAX_WEIGHT SHALL latch pm_weight, clear the location counter and go to LOAD.
REQ-011 IDLE: a command with cmd_weight of 0 or above MAX_WEIGHT SHALL pulse err the next cycle and stay in IDLE.
REQ-012 LOAD: each loc_valid&loc_ready beat SHALL, in the same cycle, drive loc_wr_en=1, loc_wr_addr=counter and loc_wr_data=loc_data, then increment the counter.
REQ-013 LOAD: the beat with counter=pm_weight-1 SHALL move to START.
REQ-014 START SHALL last one cycle with pm_start=1, then go to WAIT and clear the watchdog.
REQ-015 WAIT SHALL exit to RADDR only on a rising edge of pm_valid (pm_valid=1 with its registered previous value 0); a level already high at entry SHALL be ignored.
REQ-016 WAIT: the watchdog SHALL count every cycle; reaching TIMEOUT SHALL pulse err and return to IDLE.
REQ-017 RADDR SHALL drive pm_rd_dout=1 and pm_addr_result=word index, then go to RDATA.
REQ-018 RDATA SHALL capture pm_dout into res_data and go to OUT.
REQ-019 OUT SHALL hold res_valid=1 with res_data stable until res_ready=1; res_last=1 when index=RESULT_WORDS-1.
REQ-020 OUT: an accepted non-last beat SHALL increment the index and go to RADDR; giving a throughput of one word per 3 cycles under continuous ready.
REQ-021 OUT: the accepted last beat SHALL pulse done the next cycle and return to IDLE.
REQ-022 pm_rd_dout SHALL stay high from RADDR through OUT; loc_wr_en SHALL be 0 outside LOAD.
REQ-023 cmd_valid while not IDLE SHALL be ignored (cmd_ready=0); loc_valid outside LOAD SHALL be ignored.

Reset
REQ-024 rst=1 at any clock edge, including mid-job, SHALL force IDLE and zero all counters and outputs except cmd_ready=1; pm_weight SHALL reset to 0.

Verification
REQ-025 Happy path: cmd_weight=2, locations 0x0005 and 0x1A2B, pm_valid rising 40 cycles after pm_start, res_ready tied high -> writes to addresses 0 and 1, exactly one pm_start, 553 beats, res_last only on beat 552, one done pulse.
REQ-026 Rejects: cmd_weight=0, then cmd_weight=76 -> two err pulses, no loc_ready, state stays IDLE.
REQ-027 Backpressure: res_ready toggles 1-0-0-1 -> no beat lost or duplicated, res_data stable while stalled, beat order 0..552.
REQ-028 Stale valid: pm_valid held high from the previous job -> no exit from WAIT until it falls and rises again.
REQ-029 Timeout: TIMEOUT=100 and pm_valid held low -> err pulses at WAIT cycle 100, then IDLE with busy=0.
REQ-030 Reset mid-job: rst asserted in OUT at beat 10 -> next cycle IDLE, res_valid=0; a new job completes normally.

Source files
------------

// File: rtl/poly_mult_seq.sv
// rtl/poly_mult_seq.sv - sequencer that loads sparse locations, starts poly_mult and streams its result
module poly_mult_seq #(
   parameter int MAX_WEIGHT     = 75,
   parameter int LOG_MAX_WEIGHT = 7,
   parameter int M              = 15,
   parameter int ADDR_WIDTH     = 11,
   parameter int MEM_WIDTH      = 32,
   parameter int RESULT_WORDS   = 553,
   parameter int TIMEOUT        = 2**20
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cmd_valid,
   output logic                      cmd_ready,
   input  logic [LOG_MAX_WEIGHT:0]   cmd_weight,
   input  logic                      loc_valid,
   output logic                      loc_ready,
   input  logic [M-1:0]              loc_data,
   output logic                      loc_wr_en,
   output logic [LOG_MAX_WEIGHT-1:0] loc_wr_addr,
   output logic [M-1:0]              loc_wr_data,
   output logic                      pm_start,
   output logic [LOG_MAX_WEIGHT:0]   pm_weight,
   input  logic                      pm_valid,
   output logic                      pm_rd_dout,
   output logic [ADDR_WIDTH-1:0]     pm_addr_result,
   input  logic [MEM_WIDTH-1:0]      pm_dout,
   output logic                      res_valid,
   input  logic                      res_ready,
   output logic [MEM_WIDTH-1:0]      res_data,
   output logic                      res_last,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int WD_W = $clog2(TIMEOUT + 1);
   localparam logic [LOG_MAX_WEIGHT:0]   L_MAX_W    = (LOG_MAX_WEIGHT+1)'(MAX_WEIGHT);
   localparam logic [LOG_MAX_WEIGHT:0]   L_ONE_W    = (LOG_MAX_WEIGHT+1)'(1);
   localparam logic [LOG_MAX_WEIGHT-1:0] L_ONE_CNT  = LOG_MAX_WEIGHT'(1);
   localparam logic [WD_W-1:0]           L_WD_LAST  = WD_W'(TIMEOUT - 1);
   localparam logic [WD_W-1:0]           L_WD_ONE   = WD_W'(1);
   localparam logic [ADDR_WIDTH-1:0]     L_IDX_LAST = ADDR_WIDTH'(RESULT_WORDS - 1);
   localparam logic [ADDR_WIDTH-1:0]     L_IDX_ONE  = ADDR_WIDTH'(1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_RADDR, S_RDATA, S_OUT
   } state_t;

   state_t                    r_state, w_next;
   logic [LOG_MAX_WEIGHT:0]   r_weight;
   logic [LOG_MAX_WEIGHT-1:0] r_loc_cnt;
   logic [WD_W-1:0]           r_wdog;
   logic [ADDR_WIDTH-1:0]     r_idx;
   logic [MEM_WIDTH-1:0]      r_res_data;
   logic                      r_pm_valid_q;
   logic                      r_done;
   logic                      r_err;

   logic w_weight_ok, w_loc_last, w_pm_rise, w_wd_expire, w_idx_last;

   assign w_weight_ok = (cmd_weight != '0) && (cmd_weight <= L_MAX_W);
   assign w_loc_last  = ({1'b0, r_loc_cnt} == (r_weight - L_ONE_W));
   // A level that was already high when WAIT began is not a completion.
   assign w_pm_rise   = pm_valid & ~r_pm_valid_q;
   assign w_wd_expire = (r_wdog == L_WD_LAST);
   assign w_idx_last  = (r_idx == L_IDX_LAST);

   assign pm_weight      = r_weight;
   assign pm_addr_result = r_idx;
   assign res_data       = r_res_data;
   assign done           = r_done;
   assign err            = r_err;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Next-state and Moore/Mealy outputs.
   always_comb begin
      w_next      = r_state;
      cmd_ready   = 1'b0;
      loc_ready   = 1'b0;
      loc_wr_en   = 1'b0;
      loc_wr_addr = '0;
      loc_wr_data = '0;
      pm_start    = 1'b0;
      pm_rd_dout  = 1'b0;
      res_valid   = 1'b0;
      res_last    = 1'b0;
      busy        = 1'b1;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid && w_weight_ok) w_next = S_LOAD;
         end
         S_LOAD: begin
            loc_ready = 1'b1;
            if (loc_valid) begin
               loc_wr_en   = 1'b1;
               loc_wr_addr = r_loc_cnt;
               loc_wr_data = loc_data;
               if (w_loc_last) w_next = S_START;
            end
         end
         S_START: begin
            pm_start = 1'b1;
            w_next   = S_WAIT;
         end
         S_WAIT: begin
            if (w_pm_rise)        w_next = S_RADDR;
            else if (w_wd_expire) w_next = S_IDLE;
         end
         S_RADDR: begin
            pm_rd_dout = 1'b1;
            w_next     = S_RDATA;
         end
         S_RDATA: begin
            pm_rd_dout = 1'b1;
            w_next     = S_OUT;
         end
         S_OUT: begin
            pm_rd_dout = 1'b1;
            res_valid  = 1'b1;
            res_last   = w_idx_last;
            if (res_ready) w_next = w_idx_last ? S_IDLE : S_RADDR;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Job datapath: weight latch, location counter, watchdog, word index, output word and pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_weight     <= '0;
         r_loc_cnt    <= '0;
         r_wdog       <= '0;
         r_idx        <= '0;
         r_res_data   <= '0;
         r_pm_valid_q <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_pm_valid_q <= pm_valid;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_idx <= '0;
               if (cmd_valid) begin
                  if (w_weight_ok) begin
                     r_weight  <= cmd_weight;
                     r_loc_cnt <= '0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_LOAD:  if (loc_valid) r_loc_cnt <= r_loc_cnt + L_ONE_CNT;
            S_START: r_wdog <= '0;
            S_WAIT: begin
               r_wdog <= r_wdog + L_WD_ONE;
               if (!w_pm_rise && w_wd_expire) r_err <= 1'b1;
            end
            S_RDATA: r_res_data <= pm_dout;
            S_OUT: begin
               if (res_ready) begin
                  if (w_idx_last) begin
                     r_done <= 1'b1;
                     r_idx  <= '0;
                  end else begin
                     r_idx <= r_idx + L_IDX_ONE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_poly_mult_seq.sv
// tb/tb_poly_mult_seq.sv - self-checking bench for poly_mult_seq
module tb_poly_mult_seq;

   localparam int RW = 553;
   localparam int TO = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [7:0]  cmd_weight;
   logic        loc_valid, loc_ready;
   logic [14:0] loc_data;
   logic        loc_wr_en;
   logic [6:0]  loc_wr_addr;
   logic [14:0] loc_wr_data;
   logic        pm_start;
   logic [7:0]  pm_weight;
   logic        pm_valid;
   logic        pm_rd_dout;
   logic [10:0] pm_addr_result;
   logic [31:0] pm_dout = '0;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [31:0] res_data;
   logic        res_last;
   logic        busy, done, err;

   always #5 clk = ~clk;

   poly_mult_seq #(
      .MAX_WEIGHT(75), .LOG_MAX_WEIGHT(7), .M(15), .ADDR_WIDTH(11),
      .MEM_WIDTH(32), .RESULT_WORDS(RW), .TIMEOUT(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_weight(cmd_weight),
      .loc_valid(loc_valid), .loc_ready(loc_ready), .loc_data(loc_data),
      .loc_wr_en(loc_wr_en), .loc_wr_addr(loc_wr_addr), .loc_wr_data(loc_wr_data),
      .pm_start(pm_start), .pm_weight(pm_weight), .pm_valid(pm_valid),
      .pm_rd_dout(pm_rd_dout), .pm_addr_result(pm_addr_result), .pm_dout(pm_dout),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_last(res_last), .busy(busy), .done(done), .err(err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result memory model: one-cycle read latency, content depends on a per-job salt.
   logic [15:0] salt = '0;
   function automatic logic [31:0] mem_f(input logic [15:0] s, input logic [10:0] a);
      return (32'(a) * 32'h9E3779B1) ^ {s, 5'b0, a};
   endfunction
   always @(posedge clk) if (pm_rd_dout) pm_dout <= mem_f(salt, pm_addr_result);

   // Ready driver: tied high, or repeating 1-0-0-1 backpressure.
   logic       bp_mode = 1'b0;
   int         bp_cnt  = 0;
   logic [3:0] bp_pat  = 4'b1001;
   always @(posedge clk) begin
      #1;
      if (bp_mode) begin
         res_ready = bp_pat[bp_cnt % 4];
         bp_cnt++;
      end else begin
         res_ready = 1'b1;
      end
   end

   typedef struct { logic [31:0] data; logic last; } beat_t;
   typedef struct { logic [6:0] addr; logic [14:0] data; } locw_t;
   beat_t sb[$];
   locw_t locq[$];
   beat_t exp_b;

   int beats_seen = 0, done_cnt = 0, err_cnt = 0, start_cnt = 0, last_cnt = 0;
   logic        stalled = 1'b0;
   logic [31:0] stall_data = '0;

   // Monitor and scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst) begin
         stalled = 1'b0;
      end else begin
         if (loc_wr_en) locq.push_back('{addr: loc_wr_addr, data: loc_wr_data});
         if (pm_start) start_cnt++;
         if (done) done_cnt++;
         if (err) err_cnt++;
         if (res_valid) begin
            if (stalled) check("stall_stable", res_data, stall_data);
            if (res_ready) begin
               if (res_last) last_cnt++;
               if (sb.size() == 0) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL beat_extra: got beat %0h with no expected beat left", res_data);
               end else begin
                  exp_b = sb.pop_front();
                  check($sformatf("beat%0d_data", beats_seen), res_data, exp_b.data);
                  check($sformatf("beat%0d_last", beats_seen), res_last, exp_b.last);
               end
               beats_seen++;
            end
            stalled    = !res_ready;
            stall_data = res_data;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_expected(input logic [15:0] s);
      for (int i = 0; i < RW; i++) sb.push_back('{data: mem_f(s, 11'(i)), last: (i == RW - 1)});
   endtask

   task automatic start_job(input logic [7:0] w);
      cmd_weight = w;
      cmd_valid  = 1'b1;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < int'(w); i++) begin
         loc_valid = 1'b1;
         loc_data  = 15'(i * 37 + 5);
         tick();
      end
      loc_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0 = done_cnt;
      int k  = 0;
      while (done_cnt == d0 && k < budget) begin
         tick();
         k++;
      end
      check(name, done_cnt - d0, 1);
   endtask

   typedef struct { logic [7:0] w; logic exp_err; } cmd_vec_t;
   cmd_vec_t tv[5];

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      int s0, d0, k;
      tv[0] = '{w: 8'd0,   exp_err: 1'b1};
      tv[1] = '{w: 8'd76,  exp_err: 1'b1};
      tv[2] = '{w: 8'd255, exp_err: 1'b1};
      tv[3] = '{w: 8'd75,  exp_err: 1'b0};
      tv[4] = '{w: 8'd1,   exp_err: 1'b0};

      rst = 1'b1; cmd_valid = 1'b0; cmd_weight = '0;
      loc_valid = 1'b0; loc_data = '0; pm_valid = 1'b0;
      tick(); tick();
      check("reset_outputs",
            {cmd_ready, busy, res_valid, loc_ready, pm_rd_dout, err, done, pm_start, loc_wr_en},
            9'b1_0000_0000);
      check("reset_weight", pm_weight, 0);
      rst = 1'b0;
      tick();

      // Command acceptance / rejection table.
      for (int i = 0; i < 5; i++) begin
         cmd_weight = tv[i].w;
         cmd_valid  = 1'b1;
         tick();
         cmd_valid = 1'b0;
         check($sformatf("cmd%0d_err", i), err, tv[i].exp_err);
         check($sformatf("cmd%0d_loc_ready", i), loc_ready, !tv[i].exp_err);
         check($sformatf("cmd%0d_busy", i), busy, !tv[i].exp_err);
         if (!tv[i].exp_err) begin
            check($sformatf("cmd%0d_weight", i), pm_weight, tv[i].w);
            rst = 1'b1;
            tick();
            rst = 1'b0;
            check($sformatf("cmd%0d_abort_idle", i), busy, 0);
         end else begin
            tick();
            check($sformatf("cmd%0d_err_pulse", i), err, 0);
            check($sformatf("cmd%0d_idle", i), cmd_ready, 1);
         end
      end

      // Happy path: weight 2, fixed locations, completion 40 cycles after start.
      locq.delete();
      s0 = start_cnt; d0 = done_cnt; beats_seen = 0; last_cnt = 0;
      salt = 16'h1111;
      cmd_weight = 8'd2; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      loc_valid = 1'b1; loc_data = 15'h0005;
      tick();
      loc_data = 15'h1A2B;
      tick();
      loc_valid = 1'b0;
      check("happy_loc_writes", locq.size(), 2);
      if (locq.size() == 2) begin
         check("happy_loc0", {locq[0].addr, locq[0].data}, {7'd0, 15'h0005});
         check("happy_loc1", {locq[1].addr, locq[1].data}, {7'd1, 15'h1A2B});
      end
      check("happy_pm_start", pm_start, 1);
      push_expected(salt);
      repeat (40) tick();
      pm_valid = 1'b1;
      wait_done(5000, "happy_done");
      tick(); tick();
      check("happy_beats", beats_seen, RW);
      check("happy_last_cnt", last_cnt, 1);
      check("happy_start_cnt", start_cnt - s0, 1);
      check("happy_done_cnt", done_cnt - d0, 1);
      check("happy_sb_empty", sb.size(), 0);
      check("happy_idle", busy, 0);

      // Stale completion level plus 1-0-0-1 backpressure.
      salt = 16'h2222; beats_seen = 0;
      start_job(8'd3);
      push_expected(salt);
      repeat (30) tick();
      check("stale_no_read", pm_rd_dout, 0);
      check("stale_busy", busy, 1);
      pm_valid = 1'b0;
      tick(); tick();
      pm_valid = 1'b1;
      bp_cnt = 0; bp_mode = 1'b1;
      wait_done(8000, "bp_done");
      bp_mode = 1'b0;
      check("bp_beats", beats_seen, RW);
      check("bp_sb_empty", sb.size(), 0);

      // Watchdog expiry with completion held low.
      pm_valid = 1'b0;
      tick();
      start_job(8'd1);
      k = 0;
      while (!err && k < 300) begin
         tick();
         k++;
      end
      check("timeout_cycles", k, TO + 1);
      check("timeout_idle", {busy, cmd_ready}, 2'b01);
      tick();
      check("timeout_err_pulse", err, 0);

      // Reset while streaming beat 10, then a clean job.
      salt = 16'h3333; beats_seen = 0;
      start_job(8'd2);
      push_expected(salt);
      repeat (10) tick();
      pm_valid = 1'b1;
      k = 0;
      while (!(beats_seen == 10 && res_valid) && k < 1000) begin
         tick();
         k++;
      end
      check("rst_reach_beat10", beats_seen, 10);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_outputs", {res_valid, busy, cmd_ready, pm_rd_dout}, 4'b0010);
      sb.delete();
      pm_valid = 1'b0;
      tick();
      salt = 16'h4444; beats_seen = 0;
      start_job(8'd5);
      push_expected(salt);
      repeat (5) tick();
      pm_valid = 1'b1;
      wait_done(5000, "post_rst_done");
      check("post_rst_beats", beats_seen, RW);
      check("post_rst_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
